led_blink_arbiter: RTL and testbench

Shares the board's single active-low status LED between several internal requesters. Each requester gets an identifiable blink burst: requester k blinks k+1 times. Grants are round-robin and non-preemptive. The block sits between status-reporting logic and the LED pin, replacing a free-running blinker, and uses the same blink period convention.

---
 rtl/led_blink_arbiter.sv | 117 +++++++++++
 tb/tb_led_blink_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter sharing one active-low status LED; requester k is served
// with a burst of k+1 blinks followed by a dark gap, one service at a time.
module led_blink_arbiter #(
    parameter int DIV     = 27000000/2,
    parameter int NUM_REQ = 4
) (
    input  logic               sys_clk,
    input  logic               sys_reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               done,
    output logic               busy,
    output logic               led
);
    localparam int CW = $clog2(DIV);
    localparam int BW = $clog2(NUM_REQ + 1);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [BW-1:0]      blink_q;
    logic [IW-1:0]      last_q;
    logic [IW-1:0]      idx_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               done_q;
    logic               busy_q;
    logic               led_q;

    logic [IW-1:0]      win_d;
    logic [IW-1:0]      cand_d;
    logic [BW-1:0]      blink_d;
    logic [BW-1:0]      target_d;
    logic               phase_end;

    // Scan from the highest offset down so the nearest set bit after last_q wins.
    always_comb begin
        win_d  = last_q;
        cand_d = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand_d = IW'((int'(last_q) + i) % NUM_REQ);
            if (req[cand_d]) begin
                win_d = cand_d;
            end
        end
    end

    assign phase_end = (cnt_q == CNT_LAST);
    assign blink_d   = blink_q + BW'(1);
    assign target_d  = BW'(idx_q) + BW'(1);

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blink_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            idx_q   <= '0;
            grant_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            led_q   <= 1'b1;
        end else begin
            cnt_q  <= (state_q == IDLE || phase_end) ? '0 : cnt_q + CW'(1);
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= ON;
                        last_q  <= win_d;
                        idx_q   <= win_d;
                        grant_q <= NUM_REQ'(1) << win_d;
                        busy_q  <= 1'b1;
                        led_q   <= 1'b0;
                        blink_q <= '0;
                    end
                end
                ON: begin
                    if (phase_end) begin
                        state_q <= OFF;
                        led_q   <= 1'b1;
                    end
                end
                OFF: begin
                    if (phase_end) begin
                        blink_q <= blink_d;
                        if (blink_d == target_d) begin
                            state_q <= GAP;
                        end else begin
                            state_q <= ON;
                            led_q   <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    // done is registered, so raise it one cycle ahead of the last gap cycle.
                    if (cnt_q == CNT_PRE) begin
                        done_q <= 1'b1;
                    end
                    if (phase_end) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign led   = led_q;
endmodule

// File: tb/tb_led_blink_arbiter.sv
// Bench for led_blink_arbiter: two instances (DIV=4/NUM_REQ=4 and DIV=2/NUM_REQ=2)
// compared every cycle against a service-timeline reference model.
module tb_led_blink_arbiter;
    localparam int DIV_A = 4;
    localparam int NR_A  = 4;
    localparam int DIV_B = 2;
    localparam int NR_B  = 2;

    logic       clk = 1'b0;
    logic       sys_reset = 1'b1;
    logic [3:0] req_a = '0;
    logic [1:0] req_b = '0;
    logic [3:0] grant_a;
    logic [1:0] grant_b;
    logic       done_a, busy_a, led_a;
    logic       done_b, busy_b, led_b;

    always #5 clk = ~clk;

    led_blink_arbiter #(.DIV(DIV_A), .NUM_REQ(NR_A)) dut_a (
        .sys_clk(clk), .sys_reset(sys_reset), .req(req_a),
        .grant(grant_a), .done(done_a), .busy(busy_a), .led(led_a)
    );

    led_blink_arbiter #(.DIV(DIV_B), .NUM_REQ(NR_B)) dut_b (
        .sys_clk(clk), .sys_reset(sys_reset), .req(req_b),
        .grant(grant_b), .done(done_b), .busy(busy_b), .led(led_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: per instance, the served requester (-1 when idle), the cycle index
    // inside its service, and the round-robin pointer.
    int m_k[2]    = '{-1, -1};
    int m_c[2]    = '{0, 0};
    int m_last[2] = '{NR_A - 1, NR_B - 1};

    logic [3:0] prev_ga = '0;
    logic [3:0] rr_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int svc_len(input int k, input int dv);
        return 2 * (k + 1) * dv + dv;
    endfunction

    task automatic model_edge(input int d, input int rq, input logic rst);
        int n;
        int dv;
        bit found;
        n  = (d == 0) ? NR_A : NR_B;
        dv = (d == 0) ? DIV_A : DIV_B;
        if (rst) begin
            m_k[d]    = -1;
            m_c[d]    = 0;
            m_last[d] = n - 1;
        end else if (m_k[d] >= 0) begin
            m_c[d]++;
            if (m_c[d] == svc_len(m_k[d], dv)) m_k[d] = -1;
        end else if (rq != 0) begin
            found = 0;
            for (int i = 1; i <= n; i++) begin
                int j;
                j = (m_last[d] + i) % n;
                if (!found && rq[j]) begin
                    found     = 1;
                    m_k[d]    = j;
                    m_c[d]    = 0;
                    m_last[d] = j;
                end
            end
        end
    endtask

    task automatic check_dut(input int d, input logic [3:0] g, input logic dn,
                             input logic bz, input logic ld);
        int k, c, dv;
        logic [3:0] eg;
        logic edn, ebz, eld;
        string p;
        k  = m_k[d];
        c  = m_c[d];
        dv = (d == 0) ? DIV_A : DIV_B;
        p  = (d == 0) ? "A" : "B";
        if (k < 0) begin
            eg = '0; edn = 1'b0; ebz = 1'b0; eld = 1'b1;
        end else begin
            eg  = 4'(1) << k;
            edn = (c == svc_len(k, dv) - 1);
            ebz = 1'b1;
            eld = !(((c / dv) % 2 == 0) && (c < 2 * (k + 1) * dv));
        end
        chk({p, ".grant"}, 32'(g), 32'(eg));
        chk({p, ".done"},  32'(dn), 32'(edn));
        chk({p, ".busy"},  32'(bz), 32'(ebz));
        chk({p, ".led"},   32'(ld), 32'(eld));
    endtask

    task automatic step(input logic rst, input logic [3:0] ra, input logic [1:0] rb);
        sys_reset = rst;
        req_a     = ra;
        req_b     = rb;
        @(posedge clk);
        model_edge(0, int'(ra), rst);
        model_edge(1, int'(rb), rst);
        cyc++;
        @(negedge clk);
        check_dut(0, grant_a, done_a, busy_a, led_a);
        check_dut(1, {2'b00, grant_b}, done_b, busy_b, led_b);
        if (grant_a != 0 && prev_ga == 0) rr_q.push_back(grant_a);
        prev_ga = grant_a;
    endtask

    initial begin
        int cnt, dcnt, lcnt, t_done, t_grant;
        logic [3:0] rr_exp[4];

        // Reset held with all requests pending, then release.
        repeat (3) step(1'b1, 4'b1111, 2'b11);
        step(1'b0, 4'b1111, 2'b11);
        chk("rst.first_a", 32'(grant_a), 32'h1);
        chk("rst.first_b", 32'(grant_b), 32'h1);

        // Single burst of requester 2 on the DIV=4 instance.
        step(1'b1, 4'b0000, 2'b00);
        cnt = 0; dcnt = 0;
        step(1'b0, 4'b0100, 2'b00);
        if (grant_a == 4'b0100) cnt++;
        if (done_a) dcnt++;
        repeat (40) begin
            step(1'b0, 4'b0000, 2'b00);
            if (grant_a == 4'b0100) cnt++;
            if (done_a) dcnt++;
        end
        chk("burst.len", 32'(cnt), 32'd28);
        chk("burst.done", 32'(dcnt), 32'd1);

        // Reset in the second ON phase of requester 1, then a fresh burst.
        step(1'b0, 4'b0010, 2'b00);
        repeat (9) step(1'b0, 4'b0000, 2'b00);
        step(1'b1, 4'b0000, 2'b00);
        chk("midrst.grant", 32'(grant_a), 32'h0);
        chk("midrst.led", 32'(led_a), 32'h1);
        cnt = 0; lcnt = 0;
        step(1'b0, 4'b0010, 2'b00);
        if (grant_a == 4'b0010) cnt++;
        if (!led_a) lcnt++;
        repeat (27) begin
            step(1'b0, 4'b0000, 2'b00);
            if (grant_a == 4'b0010) cnt++;
            if (!led_a) lcnt++;
        end
        chk("midrst.len", 32'(cnt), 32'd20);
        chk("midrst.lit", 32'(lcnt), 32'd8);

        // Non-preemption: requester 0 arrives during requester 3's service.
        repeat (5) step(1'b0, 4'b0000, 2'b00);
        step(1'b0, 4'b1000, 2'b00);
        repeat (4) step(1'b0, 4'b0000, 2'b00);
        t_done = -100; t_grant = -1;
        for (int i = 0; i < 80; i++) begin
            step(1'b0, 4'b0001, 2'b00);
            if (done_a && t_done < 0) t_done = cyc;
            if (grant_a == 4'b0001 && t_grant < 0) t_grant = cyc;
        end
        chk("nonpre.latency", 32'(t_grant - t_done), 32'd2);

        // Round-robin on A with 1011; minimum config on B with 11 for 40 cycles.
        step(1'b1, 4'b0000, 2'b00);
        rr_q.delete();
        for (int i = 0; i < 100; i++) step(1'b0, 4'b1011, (i < 40) ? 2'b11 : 2'b00);
        rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            chk("rr.seq", 32'((rr_q.size() > i) ? rr_q[i] : 4'b0000), 32'(rr_exp[i]));
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
